pwm_ch_sched: RTL and testbench



---
 rtl/pwm_ch_sched_if.sv | 23 ++
 rtl/pwm_ch_sched.sv | 185 ++++++++++++++++++
 tb/tb_pwm_ch_sched.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_ch_sched_if.sv
// Command bus between the UART packet decoder and the PWM channel scheduler.
interface pwm_ch_sched_if;
   logic        cfg_valid;
   logic [7:0]  cfg_ch;
   logic [7:0]  cfg_cmd;
   logic [7:0]  cfg_duty;
   logic [16:0] cfg_dessert;
   logic [7:0]  cfg_pnum;
   logic [31:0] cfg_pat;
   logic        cfg_ready;
   logic        cfg_ack;
   logic [1:0]  cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_cmd, cfg_duty, cfg_dessert, cfg_pnum, cfg_pat,
      input  cfg_ready, cfg_ack, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_cmd, cfg_duty, cfg_dessert, cfg_pnum, cfg_pat,
      output cfg_ready, cfg_ack, cfg_err
   );
endinterface

// File: rtl/pwm_ch_sched.sv
// Per-command scheduler for a bank of pattern_pwm channels. A channel is always
// disabled and allowed to go idle before its shadow configuration is rewritten.
module pwm_ch_sched #(
   parameter int CH_NUM       = 8,
   parameter int _PAT_WIDTH   = 16,
   parameter int WAIT_TIMEOUT = 65535
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst,
   pwm_ch_sched_if.slave                cfg,
   input  logic [CH_NUM-1:0]            ch_busy,
   input  logic [CH_NUM-1:0]            ch_valid,
   output logic [CH_NUM-1:0]            ch_en,
   output logic [8*CH_NUM-1:0]          ch_duty,
   output logic [16*CH_NUM-1:0]         ch_dessert,
   output logic [8*CH_NUM-1:0]          ch_pnum,
   output logic [_PAT_WIDTH*CH_NUM-1:0] ch_pat,
   output logic [CH_NUM-1:0]            ch_done
);
   localparam logic [7:0]  CMD_STOP   = 8'h00;
   localparam logic [7:0]  CMD_START  = 8'h01;
   localparam logic [7:0]  CMD_RESUME = 8'h02;
   localparam logic [1:0]  ERR_OK     = 2'd0;
   localparam logic [1:0]  ERR_CH     = 2'd1;
   localparam logic [1:0]  ERR_CMD    = 2'd2;
   localparam logic [1:0]  ERR_TMO    = 2'd3;
   localparam logic [15:0] TMO        = 16'(WAIT_TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_DIS, S_WAIT, S_LOAD, S_ACK} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              err_q, err_d;
   logic [15:0]             wait_q, wait_d;
   logic                    cap;
   logic                    busy_sel;
   logic                    bad_ch, bad_cmd;
   logic                    ready_q, ack_q;
   logic [1:0]              cfg_err_q;
   logic [7:0]              cap_ch_q, cap_cmd_q, cap_duty_q, cap_pnum_q;
   logic [15:0]             cap_des_q;
   logic [_PAT_WIDTH-1:0]   cap_pat_q;
   logic [31:0]             pat_unused;
   logic                    des_unused;

   // Bits beyond the channel register widths are deliberately dropped.
   assign pat_unused = cfg.cfg_pat >> _PAT_WIDTH;
   assign des_unused = cfg.cfg_dessert[16];

   assign bad_ch    = int'(cfg.cfg_ch) >= CH_NUM;
   assign bad_cmd   = cfg.cfg_cmd > CMD_RESUME;

   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_ack   = ack_q;
   assign cfg.cfg_err   = cfg_err_q;

   // Busy flag of the channel targeted by the command in flight.
   always_comb begin
      busy_sel = 1'b0;
      for (int c = 0; c < CH_NUM; c++)
         if (cap_ch_q == 8'(c)) busy_sel = ch_busy[c];
   end

   // Command FSM: next state, error code and busy-wait counter.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      wait_d  = wait_q;
      cap     = 1'b0;
      case (state_q)
         S_IDLE: if (cfg.cfg_valid) begin
            cap   = 1'b1;
            err_d = ERR_OK;
            if (bad_ch) begin
               err_d   = ERR_CH;
               state_d = S_ACK;
            end else if (bad_cmd) begin
               err_d   = ERR_CMD;
               state_d = S_ACK;
            end else begin
               state_d = S_DIS;
            end
         end
         S_DIS: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q >= 16'd2 && !busy_sel) begin
               state_d = S_LOAD;
            end else if (wait_q == TMO) begin
               err_d   = ERR_TMO;   // load anyway, but report the stuck channel
               state_d = S_LOAD;
            end
            if (wait_q < TMO) wait_d = wait_q + 16'd1;
         end
         S_LOAD:  state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state plus registered handshake outputs derived from the next state.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= S_IDLE;
         err_q     <= ERR_OK;
         wait_q    <= '0;
         ready_q   <= 1'b1;
         ack_q     <= 1'b0;
         cfg_err_q <= ERR_OK;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         wait_q    <= wait_d;
         ready_q   <= (state_d == S_IDLE);
         ack_q     <= (state_d == S_ACK);
         cfg_err_q <= (state_d == S_ACK) ? err_d : ERR_OK;
      end
   end

   // Latch the whole command when it is accepted in IDLE.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cap_ch_q   <= '0;
         cap_cmd_q  <= '0;
         cap_duty_q <= '0;
         cap_des_q  <= '0;
         cap_pnum_q <= '0;
         cap_pat_q  <= '0;
      end else if (cap) begin
         cap_ch_q   <= cfg.cfg_ch;
         cap_cmd_q  <= cfg.cfg_cmd;
         cap_duty_q <= cfg.cfg_duty;
         cap_des_q  <= cfg.cfg_dessert[15:0];
         cap_pnum_q <= cfg.cfg_pnum;
         cap_pat_q  <= cfg.cfg_pat[_PAT_WIDTH-1:0];
      end
   end

   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic                  sel, load;
      logic                  en_q, done_q;
      logic [7:0]            duty_q, pnum_q;
      logic [15:0]           des_q;
      logic [_PAT_WIDTH-1:0] pat_q;

      assign sel  = (cap_ch_q == 8'(c));
      assign load = (state_q == S_LOAD) && sel;

      assign ch_en[c]                           = en_q;
      assign ch_done[c]                         = done_q;
      assign ch_duty[8*c +: 8]                  = duty_q;
      assign ch_dessert[16*c +: 16]             = des_q;
      assign ch_pnum[8*c +: 8]                  = pnum_q;
      assign ch_pat[_PAT_WIDTH*c +: _PAT_WIDTH] = pat_q;

      // Channel enable/done: DIS and LOAD of this channel override end-of-burst.
      always_ff @(posedge sys_clk or posedge sys_rst) begin
         if (sys_rst) begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            duty_q <= '0;
            des_q  <= '0;
            pnum_q <= '0;
            pat_q  <= '0;
         end else begin
            if (state_q == S_DIS && sel) begin
               en_q <= 1'b0;
            end else if (load && cap_cmd_q != CMD_STOP) begin
               en_q   <= 1'b1;
               done_q <= 1'b0;
            end else if (ch_valid[c] && en_q) begin
               en_q   <= 1'b0;
               done_q <= 1'b1;
            end
            if (load && cap_cmd_q == CMD_START) begin
               duty_q <= cap_duty_q;
               des_q  <= cap_des_q;
               pnum_q <= cap_pnum_q;
               pat_q  <= cap_pat_q;
            end
         end
      end
   end
endmodule

// File: tb/tb_pwm_ch_sched.sv
// Directed bench for pwm_ch_sched: vector table plus multi-cycle corner sequences.
module tb_pwm_ch_sched;
   localparam int CH  = 8;
   localparam int PW  = 16;
   localparam int TMO = 24;

   logic            sys_clk = 1'b0;
   logic            sys_rst = 1'b1;
   logic [CH-1:0]   ch_busy = '0;
   logic [CH-1:0]   ch_valid = '0;
   logic [CH-1:0]   ch_en, ch_done;
   logic [8*CH-1:0] ch_duty, ch_pnum;
   logic [16*CH-1:0] ch_dessert;
   logic [PW*CH-1:0] ch_pat;

   pwm_ch_sched_if cfg_if();

   pwm_ch_sched #(.CH_NUM(CH), ._PAT_WIDTH(PW), .WAIT_TIMEOUT(TMO)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .cfg        (cfg_if.slave),
      .ch_busy    (ch_busy),
      .ch_valid   (ch_valid),
      .ch_en      (ch_en),
      .ch_duty    (ch_duty),
      .ch_dessert (ch_dessert),
      .ch_pnum    (ch_pnum),
      .ch_pat     (ch_pat),
      .ch_done    (ch_done)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [7:0]  ch;
      logic [7:0]  cmd;
      logic [7:0]  duty;
      logic [16:0] des;
      logic [7:0]  pnum;
      logic [31:0] pat;
      logic [1:0]  err;
      int          lat;
      logic [7:0]  en;
   } vec_t;

   int checks = 0;
   int failures = 0;

   logic [CH-1:0][7:0]  m_duty, m_pnum;
   logic [CH-1:0][15:0] m_des, m_pat;

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_cmd(input logic [7:0] ch, input logic [7:0] cmd, input logic [7:0] duty,
                          input logic [16:0] des, input logic [7:0] pnum, input logic [31:0] pat);
      cfg_if.cfg_ch      = ch;
      cfg_if.cfg_cmd     = cmd;
      cfg_if.cfg_duty    = duty;
      cfg_if.cfg_dessert = des;
      cfg_if.cfg_pnum    = pnum;
      cfg_if.cfg_pat     = pat;
   endtask

   task automatic strobe;
      cfg_if.cfg_valid = 1'b1;
      tick;
      cfg_if.cfg_valid = 1'b0;
   endtask

   // Ticks after the capture edge until cfg_ack is seen (0 = ack right after capture).
   task automatic wait_ack(input string nm, output int n);
      n = -1;
      for (int i = 0; i < 100; i++) begin
         if (cfg_if.cfg_ack === 1'b1) begin
            n = i;
            break;
         end
         tick;
      end
      if (n < 0) begin
         checks++;
         failures++;
         $display("FAIL %s_ack_timeout: got no ack expected ack within 100 cycles", nm);
      end
   endtask

   task automatic model_load(input logic [7:0] ch, input logic [7:0] duty, input logic [16:0] des,
                             input logic [7:0] pnum, input logic [31:0] pat);
      m_duty[ch[2:0]] = duty;
      m_des[ch[2:0]]  = des[15:0];
      m_pnum[ch[2:0]] = pnum;
      m_pat[ch[2:0]]  = pat[15:0];
   endtask

   task automatic chk_shadow(input string nm);
      chk({nm, "_duty"}, ch_duty, m_duty);
      chk({nm, "_des"},  ch_dessert, m_des);
      chk({nm, "_pnum"}, ch_pnum, m_pnum);
      chk({nm, "_pat"},  ch_pat, m_pat);
   endtask

   vec_t tbl[9];

   initial begin
      int n, bad, acks;

      tbl[0] = '{8'd2, 8'h01, 8'd50,  17'd100,     8'd3, 32'h0000_00FF, 2'd0, 5, 8'h04};
      tbl[1] = '{8'd5, 8'h01, 8'hFF,  17'h1ABCD,   8'd0, 32'hDEAD_BEEF, 2'd0, 5, 8'h24};
      tbl[2] = '{8'd9, 8'h01, 8'd1,   17'd1,       8'd1, 32'h1,         2'd1, 0, 8'h24};
      tbl[3] = '{8'd0, 8'h07, 8'd1,   17'd1,       8'd1, 32'h1,         2'd2, 0, 8'h24};
      tbl[4] = '{8'd8, 8'h07, 8'd1,   17'd1,       8'd1, 32'h1,         2'd1, 0, 8'h24};
      tbl[5] = '{8'd5, 8'h00, 8'd3,   17'd3,       8'd3, 32'h3,         2'd0, 5, 8'h04};
      tbl[6] = '{8'd5, 8'h02, 8'd4,   17'd4,       8'd4, 32'h4,         2'd0, 5, 8'h24};
      tbl[7] = '{8'd7, 8'h01, 8'd1,   17'd1,       8'd1, 32'h1,         2'd0, 5, 8'hA4};
      tbl[8] = '{8'd7, 8'h00, 8'd9,   17'd9,       8'd9, 32'h9,         2'd0, 5, 8'h24};

      m_duty = '0; m_des = '0; m_pnum = '0; m_pat = '0;
      cfg_if.cfg_valid = 1'b0;
      set_cmd(8'd0, 8'd0, 8'd0, 17'd0, 8'd0, 32'd0);

      // reset
      repeat (2) tick;
      chk("rst_en", ch_en, 8'h00);
      chk("rst_ack", cfg_if.cfg_ack, 1'b0);
      chk_shadow("rst");
      sys_rst = 1'b0;
      chk("rst_ready", cfg_if.cfg_ready, 1'b1);
      chk("rst_err", cfg_if.cfg_err, 2'd0);
      chk("rst_done", ch_done, 8'h00);

      // vector table
      for (int i = 0; i < 9; i++) begin
         set_cmd(tbl[i].ch, tbl[i].cmd, tbl[i].duty, tbl[i].des, tbl[i].pnum, tbl[i].pat);
         strobe;
         wait_ack($sformatf("v%0d", i), n);
         chk($sformatf("v%0d_lat", i), n, tbl[i].lat);
         chk($sformatf("v%0d_err", i), cfg_if.cfg_err, tbl[i].err);
         chk($sformatf("v%0d_ready_in_ack", i), cfg_if.cfg_ready, 1'b0);
         chk($sformatf("v%0d_en", i), ch_en, tbl[i].en);
         chk($sformatf("v%0d_done", i), ch_done, 8'h00);
         if (tbl[i].err == 2'd0 && tbl[i].cmd == 8'h01)
            model_load(tbl[i].ch, tbl[i].duty, tbl[i].des, tbl[i].pnum, tbl[i].pat);
         chk_shadow($sformatf("v%0d", i));
         tick;
         chk($sformatf("v%0d_ready", i), cfg_if.cfg_ready, 1'b1);
         chk($sformatf("v%0d_ack_1cyc", i), cfg_if.cfg_ack, 1'b0);
      end

      // busy held for 20 cycles: load waits, enable stays low meanwhile
      ch_busy[2] = 1'b1;
      set_cmd(8'd2, 8'h01, 8'd60, 17'd200, 8'd4, 32'h0000_A5A5);
      strobe;
      tick;
      bad = 0;
      for (int i = 0; i < 19; i++) begin
         if (ch_en[2] !== 1'b0 || cfg_if.cfg_ack !== 1'b0) bad++;
         tick;
      end
      chk("busy_en_low", bad, 0);
      ch_busy[2] = 1'b0;
      wait_ack("busy", n);
      chk("busy_lat", n, 2);
      chk("busy_err", cfg_if.cfg_err, 2'd0);
      chk("busy_en", ch_en, 8'h24);
      model_load(8'd2, 8'd60, 17'd200, 8'd4, 32'h0000_A5A5);
      chk_shadow("busy");
      tick;

      // busy stuck: timeout still loads, err=3
      ch_busy[1] = 1'b1;
      set_cmd(8'd1, 8'h01, 8'd11, 17'd22, 8'd33, 32'h0000_1234);
      strobe;
      wait_ack("tmo", n);
      chk("tmo_lat", n, TMO + 3);
      chk("tmo_err", cfg_if.cfg_err, 2'd3);
      chk("tmo_en", ch_en, 8'h26);
      model_load(8'd1, 8'd11, 17'd22, 8'd33, 32'h0000_1234);
      chk_shadow("tmo");
      ch_busy[1] = 1'b0;
      tick;

      // end-of-burst on running ch2, and on disabled ch3 (ignored)
      ch_valid = 8'h0C;
      tick;
      ch_valid = '0;
      chk("burst_en", ch_en, 8'h22);
      chk("burst_done", ch_done, 8'h04);

      // RESUME ch2: re-enable, clear done, shadows untouched
      set_cmd(8'd2, 8'h02, 8'h99, 17'h1_5555, 8'h77, 32'h6666_6666);
      strobe;
      wait_ack("resume", n);
      chk("resume_lat", n, 5);
      chk("resume_err", cfg_if.cfg_err, 2'd0);
      chk("resume_en", ch_en, 8'h26);
      chk("resume_done", ch_done, 8'h00);
      chk_shadow("resume");
      tick;

      // end-of-burst arriving in the LOAD cycle of the same channel
      strobe;
      repeat (4) tick;
      ch_valid[2] = 1'b1;
      tick;
      ch_valid = '0;
      chk("coll_ack", cfg_if.cfg_ack, 1'b1);
      chk("coll_en", ch_en, 8'h26);
      chk("coll_done", ch_done, 8'h00);
      tick;

      // second strobe while not ready is dropped
      set_cmd(8'd0, 8'h01, 8'd7, 17'd8, 8'd9, 32'h0000_0077);
      strobe;
      tick;
      chk("dbl_ready", cfg_if.cfg_ready, 1'b0);
      set_cmd(8'd3, 8'h01, 8'd70, 17'd80, 8'd90, 32'h0000_7700);
      strobe;
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         if (cfg_if.cfg_ack === 1'b1) acks++;
         tick;
      end
      chk("dbl_acks", acks, 1);
      chk("dbl_en", ch_en, 8'h27);
      model_load(8'd0, 8'd7, 17'd8, 8'd9, 32'h0000_0077);
      chk_shadow("dbl");

      // reset during WAIT aborts the command
      set_cmd(8'd4, 8'h01, 8'd44, 17'd45, 8'd46, 32'h0000_0047);
      strobe;
      repeat (2) tick;
      sys_rst = 1'b1;
      #1;
      chk("mrst_en", ch_en, 8'h00);
      chk("mrst_done", ch_done, 8'h00);
      chk("mrst_ack", cfg_if.cfg_ack, 1'b0);
      m_duty = '0; m_des = '0; m_pnum = '0; m_pat = '0;
      chk_shadow("mrst");
      tick;
      sys_rst = 1'b0;
      chk("mrst_ready", cfg_if.cfg_ready, 1'b1);
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         if (cfg_if.cfg_ack !== 1'b0 || ch_en !== 8'h00) acks++;
         tick;
      end
      chk("mrst_no_ack", acks, 0);
      chk_shadow("mrst_post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
